// File: rtl/fa_check_pkg.sv
// ---------------------------------------------------------------------------
// fa_check_pkg
//
// Shared definitions for the full-adder built-in self-test checker:
//   - state_t : checker FSM states (IDLE, DRIVE, SAMPLE, DONE)
//   - VEC_W   : width of the stimulus vector {a,b,c}
//   - NUM_VEC : number of vectors in one exhaustive sweep
//   - FAIL_W  : width of the first-failure record {a,b,c,sum,carry}
// ---------------------------------------------------------------------------
package fa_check_pkg;

    localparam int VEC_W   = 3;
    localparam int NUM_VEC = 8;
    localparam int FAIL_W  = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/full_adder_model.sv
// ---------------------------------------------------------------------------
// full_adder_model
//
// Combinational golden model of a single-bit full adder, used by the checker
// as the reference response for each stimulus vector.
//
// Ports:
//   a, b, c    in   1  adder operands and carry-in
//   exp_sum    out  1  expected sum   = a ^ b ^ c
//   exp_carry  out  1  expected carry = majority(a, b, c)
// ---------------------------------------------------------------------------
module full_adder_model (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic exp_sum,
    output logic exp_carry
);

    assign exp_sum   = a ^ b ^ c;
    assign exp_carry = (a & b) | (b & c) | (a & c);

endmodule

// File: rtl/full_adder_checker.sv
// ---------------------------------------------------------------------------
// full_adder_checker
//
// Exhaustive stimulus generator and response checker for a single-bit full
// adder. A run sweeps {a,b,c} from 0 to 7, PASSES times, holding each vector
// for SETTLE_CYCLES cycles before sampling the adder response and comparing
// it with the built-in golden model.
//
// Parameters:
//   SETTLE_CYCLES  cycles each vector is held in DRIVE before SAMPLE (>= 1)
//   PASSES         number of full 8-vector sweeps per run (>= 1)
//   ERR_W          width of the saturating mismatch counter
//
// Ports:
//   clk         in   1      sole clock, rising edge
//   rst_n       in   1      synchronous active-low reset
//   start       in   1      begin a run (only looked at in IDLE)
//   busy        out  1      run in progress
//   done        out  1      one-cycle pulse at run end
//   pass        out  1      last run had zero mismatches (valid from done)
//   err_count   out  ERR_W  saturating mismatch count
//   first_fail  out  5      {a,b,c,observed sum,observed carry} of 1st miss
//   fail_seen   out  1      first_fail holds a captured mismatch
//   dut_a/b/c   out  1      registered stimulus to the adder under test
//   dut_sum     in   1      adder sum response
//   dut_carry   in   1      adder carry response
//
// Handshake: start is a request that is accepted only when the FSM is in
// IDLE; busy rises one cycle after the accepting edge and stays high until
// the edge that raises done; done is a single-cycle completion pulse, and
// pass/err_count/first_fail/fail_seen are stable from done until the next
// accepted start. There is no backpressure.
//
// Build option:
//   FA_CHECK_STOP_ON_FAIL_EN  when defined, the first mismatch ends the run
//                             immediately (SAMPLE -> DONE, pass = 0).
// ---------------------------------------------------------------------------
module full_adder_checker
    import fa_check_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int PASSES        = 1,
    parameter int ERR_W         = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [FAIL_W-1:0] first_fail,
    output logic              fail_seen,
    output logic              dut_a,
    output logic              dut_b,
    output logic              dut_c,
    input  logic              dut_sum,
    input  logic              dut_carry
);

    localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;

    localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [PASS_W-1:0] PASS_LAST   = PASS_W'(PASSES - 1);
    localparam logic [VEC_W-1:0]  VEC_LAST    = VEC_W'(NUM_VEC - 1);
    localparam logic [ERR_W-1:0]  ERR_MAX     = '1;

    state_t             state;
    state_t             next_state;
    logic [VEC_W-1:0]   vec;
    logic [PASS_W-1:0]  pass_cnt;
    logic [SET_W-1:0]   settle_cnt;
    // Low only in the first DRIVE cycle of a run: the stimulus register has
    // not yet been loaded with vector 0, so that cycle does not count toward
    // the settle time.
    logic               primed;

    logic               exp_sum;
    logic               exp_carry;
    logic               mismatch;
    logic               last_vec;
    logic               stop_now;

    // Golden model sees exactly what the adder sees.
    full_adder_model u_model (
        .a         (dut_a),
        .b         (dut_b),
        .c         (dut_c),
        .exp_sum   (exp_sum),
        .exp_carry (exp_carry)
    );

    assign mismatch = (state == SAMPLE) &&
                      ({dut_sum, dut_carry} != {exp_sum, exp_carry});
    assign last_vec = (vec == VEC_LAST) && (pass_cnt == PASS_LAST);

`ifdef FA_CHECK_STOP_ON_FAIL_EN
    assign stop_now = mismatch;
`else
    assign stop_now = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = DRIVE;
                end
            end
            DRIVE: begin
                if (primed && (settle_cnt == SETTLE_LAST)) begin
                    next_state = SAMPLE;
                end
            end
            SAMPLE: begin
                if (last_vec || stop_now) begin
                    next_state = DONE;
                end else begin
                    next_state = DRIVE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, counters, stimulus and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            vec        <= '0;
            pass_cnt   <= '0;
            settle_cnt <= '0;
            primed     <= 1'b0;
            err_count  <= '0;
            first_fail <= '0;
            fail_seen  <= 1'b0;
            pass       <= 1'b0;
            dut_a      <= 1'b0;
            dut_b      <= 1'b0;
            dut_c      <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (start) begin
                        vec        <= '0;
                        pass_cnt   <= '0;
                        settle_cnt <= '0;
                        primed     <= 1'b0;
                        err_count  <= '0;
                        first_fail <= '0;
                        fail_seen  <= 1'b0;
                        pass       <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (!primed) begin
                        {dut_a, dut_b, dut_c} <= vec;
                        primed                <= 1'b1;
                    end else if (next_state == SAMPLE) begin
                        settle_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                SAMPLE: begin
                    if (mismatch) begin
                        if (err_count != ERR_MAX) begin
                            err_count <= err_count + 1'b1;
                        end
                        if (!fail_seen) begin
                            first_fail <= {vec, dut_sum, dut_carry};
                        end
                        // fail_seen doubles as the sticky error flag, so a
                        // saturated counter can never mask a failure.
                        fail_seen <= 1'b1;
                    end
                    if (next_state == DONE) begin
                        pass <= ~(fail_seen | mismatch);
                    end else begin
                        // Load the next vector directly into the stimulus
                        // register so it is stable for the whole DRIVE span.
                        vec                   <= vec + 1'b1;
                        {dut_a, dut_b, dut_c} <= vec + 1'b1;
                        if (vec == VEC_LAST) begin
                            pass_cnt <= pass_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    // Results and stimulus hold; FSM returns to IDLE.
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Status outputs (decoded from registered state)
    // ------------------------------------------------------------------
    assign busy = ((state == DRIVE) && primed) || (state == SAMPLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_full_adder_checker.sv
module tb_full_adder_checker;
    import fa_check_pkg::*;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // DUT 1: defaults (SETTLE=1, PASSES=1, ERR_W=4), adder with fault modes
    // ------------------------------------------------------------------
    logic        start;
    logic        busy, done, pass, fail_seen;
    logic [3:0]  err_count;
    logic [4:0]  first_fail;
    logic        dut_a, dut_b, dut_c;
    logic        sum1, carry1;
    int          mode;

    full_adder_checker u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .first_fail (first_fail),
        .fail_seen  (fail_seen),
        .dut_a      (dut_a),
        .dut_b      (dut_b),
        .dut_c      (dut_c),
        .dut_sum    (sum1),
        .dut_carry  (carry1)
    );

    // mode 0: good adder, 1: carry stuck 0, 2: sum stuck 1, 3: carry inverted
    always_comb begin
        sum1   = dut_a ^ dut_b ^ dut_c;
        carry1 = (dut_a & dut_b) | (dut_b & dut_c) | (dut_a & dut_c);
        case (mode)
            1: carry1 = 1'b0;
            2: sum1   = 1'b1;
            3: carry1 = ~((dut_a & dut_b) | (dut_b & dut_c) | (dut_a & dut_c));
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // DUT 2: ERR_W=2, PASSES=2, adder with inverted sum
    // ------------------------------------------------------------------
    logic        start2;
    logic        busy2, done2, pass2, seen2;
    logic [1:0]  err2;
    logic [4:0]  ff2;
    logic        a2, b2, c2;
    logic        sum2, carry2;

    assign sum2   = ~(a2 ^ b2 ^ c2);
    assign carry2 = (a2 & b2) | (b2 & c2) | (a2 & c2);

    full_adder_checker #(.SETTLE_CYCLES(1), .PASSES(2), .ERR_W(2)) u_dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start2),
        .busy       (busy2),
        .done       (done2),
        .pass       (pass2),
        .err_count  (err2),
        .first_fail (ff2),
        .fail_seen  (seen2),
        .dut_a      (a2),
        .dut_b      (b2),
        .dut_c      (c2),
        .dut_sum    (sum2),
        .dut_carry  (carry2)
    );

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Expected run records: len = cycles from accepting edge to done.
    typedef struct {
        int         mode;
        int         len;
        logic [3:0] err;
        logic [4:0] ff;
        logic       seen;
        logic       pass_exp;
    } run_t;

    run_t tbl[4];

    task automatic run_entry(input int idx);
        run_t e;
        logic [31:0] exp_v;
        e    = tbl[idx];
        mode = e.mode;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk($sformatf("run%0d busy_at_accept", idx), busy, 0);
        // Expected stimulus sequence: each vector held 2 cycles.
        exp_q.delete();
        for (int n = 1; n <= e.len; n++) begin
            exp_q.push_back((n < e.len) ? (n - 1) / 2 : (e.len - 3) / 2);
        end
        for (int n = 1; n <= e.len; n++) begin
            @(negedge clk);
            exp_v = exp_q.pop_front();
            chk($sformatf("run%0d vec n=%0d", idx, n), {dut_a, dut_b, dut_c}, exp_v);
            chk($sformatf("run%0d busy n=%0d", idx, n), busy, (n < e.len));
            chk($sformatf("run%0d done n=%0d", idx, n), done, (n == e.len));
        end
        chk($sformatf("run%0d err_count", idx), err_count, e.err);
        chk($sformatf("run%0d first_fail", idx), first_fail, e.ff);
        chk($sformatf("run%0d fail_seen", idx), fail_seen, e.seen);
        chk($sformatf("run%0d pass", idx), pass, e.pass_exp);
        @(negedge clk);
        chk($sformatf("run%0d done_one_cycle", idx), done, 0);
        chk($sformatf("run%0d pass_held", idx), pass, e.pass_exp);
    endtask

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
    initial begin
        #200000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    int n2;
    int d2_len;
    logic [1:0] d2_err;

    initial begin
        tbl[0] = '{0, 17, 4'd0, 5'b00000, 1'b0, 1'b1};
`ifdef FA_CHECK_STOP_ON_FAIL_EN
        tbl[1] = '{1,  9, 4'd1, 5'b01100, 1'b1, 1'b0};
        tbl[2] = '{2,  3, 4'd1, 5'b00010, 1'b1, 1'b0};
        tbl[3] = '{3,  3, 4'd1, 5'b00001, 1'b1, 1'b0};
        d2_len = 3;
        d2_err = 2'd1;
`else
        tbl[1] = '{1, 17, 4'd4, 5'b01100, 1'b1, 1'b0};
        tbl[2] = '{2, 17, 4'd4, 5'b00010, 1'b1, 1'b0};
        tbl[3] = '{3, 17, 4'd8, 5'b00001, 1'b1, 1'b0};
        d2_len = 33;
        d2_err = 2'd3;
`endif
        rst_n  = 1'b0;
        start  = 1'b0;
        start2 = 1'b0;
        mode   = 0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst pass", pass, 0);
        chk("rst err_count", err_count, 0);
        chk("rst first_fail", first_fail, 0);
        chk("rst fail_seen", fail_seen, 0);
        chk("rst dut_abc", {dut_a, dut_b, dut_c}, 0);
        chk("rst2 busy", busy2, 0);
        chk("rst2 err", err2, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven runs on DUT 1
        for (int i = 0; i < 4; i++) begin
            run_entry(i);
        end

        // DUT 2: saturation over two passes with inverted sum
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        n2 = 0;
        while (done2 !== 1'b1 && n2 < 100) begin
            @(negedge clk);
            n2++;
        end
        chk("d2 run_length", n2, d2_len);
        chk("d2 err_sat", err2, d2_err);
        chk("d2 pass", pass2, 0);
        chk("d2 fail_seen", seen2, 1);
        chk("d2 first_fail", ff2, 5'b00010);
        // start asserted during the DONE cycle must be ignored
        start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        @(negedge clk);
        chk("d2 start_in_done_ignored", busy2, 0);

        // Start during busy, then reset mid-run
        mode = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int n = 1; n <= 11; n++) begin
            @(negedge clk);
            chk($sformatf("mid vec n=%0d", n), {dut_a, dut_b, dut_c}, (n - 1) / 2);
            chk($sformatf("mid busy n=%0d", n), busy, 1);
            if (n == 1) begin
                chk("mid start_clears err", err_count, 0);
                chk("mid start_clears seen", fail_seen, 0);
                chk("mid start_clears ff", first_fail, 0);
                chk("mid start_clears pass", pass, 0);
            end
            if (n == 9)  start = 1'b1;
            if (n == 10) start = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst busy", busy, 0);
        chk("midrst done", done, 0);
        chk("midrst pass", pass, 0);
        chk("midrst err_count", err_count, 0);
        chk("midrst first_fail", first_fail, 0);
        chk("midrst fail_seen", fail_seen, 0);
        chk("midrst dut_abc", {dut_a, dut_b, dut_c}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst stays_idle", busy, 0);

        // Restart after reset runs a full clean sweep from vector 0
        run_entry(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
